mcu_bus_initiator: RTL and testbench

MCU-side initiator for the FPGA ECC bridge bus. Converts single-word read/write requests from an internal valid/ready port into the active-low `chip_sel`/`write_en` strobe sequence, the `ecc_sel` mode bit and the 16-bit bidirectional data phase that the Hamming bridge answers on. It owns bus direction, wait states and turnaround, and returns read data or a write acknowledge on a response port. The tristate pad itself sits in the top level, driven from `bus_dout`/`bus_oe`.

---
 rtl/mcu_bus_initiator.sv | 112 +++++++++++
 tb/tb_mcu_bus_initiator.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_initiator.sv
// MCU-side initiator for the ECC bridge bus: turns single-word valid/ready
// requests into chip_sel/write_en strobes, a timed data phase and a response pulse.
module mcu_bus_initiator #(
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_ecc,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_was_write,
    output logic              chip_sel,
    output logic              write_en,
    output logic              ecc_sel,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_din
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        TURN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic              wr_q;
    logic              ecc_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;

    assign accept        = (state == IDLE) && req_valid;
    assign ecc_sel       = ecc_q;
    assign bus_dout      = dout_q;
    assign rsp_rdata     = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All bus strobes decode from the state register so they switch on the same edge.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        chip_sel      = 1'b1;
        write_en      = 1'b1;
        bus_oe        = 1'b0;
        rsp_valid     = 1'b0;
        rsp_was_write = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                chip_sel = 1'b0;
                write_en = ~wr_q;
                bus_oe   = wr_q;
                if (wait_cnt == 4'd0) begin
                    state_nxt = TURN;
                end
            end
            TURN: begin
                rsp_valid     = 1'b1;
                rsp_was_write = wr_q;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counter is loaded only at acceptance, so it stops at zero and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            wr_q     <= 1'b0;
            ecc_q    <= 1'b1;
            dout_q   <= '0;
            rdata_q  <= '0;
        end else if (accept) begin
            wait_cnt <= 4'(WAIT_CYCLES);
            wr_q     <= req_write;
            ecc_q    <= req_ecc;
            dout_q   <= req_wdata;
        end else if (state == ACCESS) begin
            if (wait_cnt == 4'd0) begin
                if (!wr_q) begin
                    rdata_q <= bus_din;
                end
            end else begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mcu_bus_initiator.sv
// Bench for mcu_bus_initiator: two instances (WAIT_CYCLES=2 and 0) compared every
// cycle against a phase-count transaction model, plus directed scenario checks.
module tb_mcu_bus_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rv = '0, rw = '0, recc = '0;
    logic [15:0] wd [2];
    logic [15:0] din [2];
    logic [1:0]  o_ready, o_rsp, o_ww, o_cs, o_we, o_ecc, o_oe;
    logic [15:0] o_rdata [2];
    logic [15:0] o_dout [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [1:0] prev_rsp = '0;

    // Transaction model: phase counts cycles since acceptance (0 = idle).
    int          W [2] = '{2, 0};
    int          m_phase [2];
    logic        m_wr [2];
    logic        m_ecc [2];
    logic [15:0] m_dout [2];
    logic [15:0] m_rdata [2];

    always #5 clk = ~clk;

    mcu_bus_initiator #(.DATA_W(16), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(o_ready[0]),
        .req_write(rw[0]), .req_wdata(wd[0]), .req_ecc(recc[0]),
        .rsp_valid(o_rsp[0]), .rsp_rdata(o_rdata[0]), .rsp_was_write(o_ww[0]),
        .chip_sel(o_cs[0]), .write_en(o_we[0]), .ecc_sel(o_ecc[0]),
        .bus_dout(o_dout[0]), .bus_oe(o_oe[0]), .bus_din(din[0])
    );

    mcu_bus_initiator #(.DATA_W(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(o_ready[1]),
        .req_write(rw[1]), .req_wdata(wd[1]), .req_ecc(recc[1]),
        .rsp_valid(o_rsp[1]), .rsp_rdata(o_rdata[1]), .rsp_was_write(o_ww[1]),
        .chip_sel(o_cs[1]), .write_en(o_we[1]), .ecc_sel(o_ecc[1]),
        .bus_dout(o_dout[1]), .bus_oe(o_oe[1]), .bus_din(din[1])
    );

    function automatic logic [38:0] obs_vec(int i);
        return {o_ready[i], o_rsp[i], o_ww[i], o_cs[i], o_we[i], o_ecc[i], o_oe[i],
                o_dout[i], o_rdata[i]};
    endfunction

    function automatic logic [38:0] exp_vec(int i);
        logic access, turn;
        access = (m_phase[i] >= 1) && (m_phase[i] <= W[i] + 1);
        turn   = (m_phase[i] == W[i] + 2);
        return {m_phase[i] == 0, turn, turn && m_wr[i], !access, !(access && m_wr[i]),
                m_ecc[i], access && m_wr[i], m_dout[i], m_rdata[i]};
    endfunction

    task automatic model_step(int i);
        if (rst) begin
            m_phase[i] = 0; m_wr[i] = 1'b0; m_ecc[i] = 1'b1;
            m_dout[i] = '0; m_rdata[i] = '0;
        end else if (m_phase[i] == 0) begin
            if (rv[i]) begin
                m_phase[i] = 1; m_wr[i] = rw[i]; m_ecc[i] = recc[i]; m_dout[i] = wd[i];
            end
        end else if (m_phase[i] == W[i] + 2) begin
            m_phase[i] = 0;
        end else begin
            if (m_phase[i] == W[i] + 1 && !m_wr[i]) m_rdata[i] = din[i];
            m_phase[i] = m_phase[i] + 1;
        end
    endtask

    // One clock: advance the model at the edge, then watch the bus invariants.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_oe[i] && (o_cs[i] || o_we[i])) begin
                errors++;
                $display("FAIL oe_contention inst%0d cyc%0d: oe=1 cs=%b we=%b, need cs=0 we=0", i, cyc, o_cs[i], o_we[i]);
            end
            checks++;
            if (o_rsp[i] && prev_rsp[i]) begin
                errors++;
                $display("FAIL rsp_double inst%0d cyc%0d: rsp_valid high 2 cycles, need 1", i, cyc);
            end
            prev_rsp[i] = o_rsp[i];
            din[i] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rv = 2'b11; rw = 2'b11; recc = 2'b00;
        wd[0] = 16'h1234; wd[1] = 16'h4321;
        cycle(); cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %h want %h", i, obs_vec(i), exp_vec(i));
            end
            checks++;
            if (o_ready[i] !== 1'b1 || o_ecc[i] !== 1'b1 || o_cs[i] !== 1'b1 || o_dout[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_accept inst%0d: ready=%b ecc=%b cs=%b dout=%h, need 1 1 1 0000",
                         i, o_ready[i], o_ecc[i], o_cs[i], o_dout[i]);
            end
        end
        rst = 1'b0; rv = 2'b00;
        cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL reset_release inst%0d: got %h want %h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_write();
        int nstrobe = 0, npulse = 0, nlow = 0;
        logic acc;
        rw[0] = 1'b1; wd[0] = 16'hA5A5; recc[0] = 1'b1; rv[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            acc = rv[0] && o_ready[0];
            cycle();
            if (acc) rv[0] = 1'b0;
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL write_trace cyc%0d: got %h want %h", cyc, obs_vec(0), exp_vec(0));
            end
            if (!o_cs[0] && !o_we[0] && o_oe[0] && o_dout[0] == 16'hA5A5) nstrobe++;
            if (o_rsp[0]) begin
                npulse++;
                checks++;
                if (o_ww[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL write_was_write: got %b want 1", o_ww[0]);
                end
            end
            if (!o_ready[0]) nlow++;
        end
        checks++;
        if (nstrobe != 3) begin errors++; $display("FAIL write_strobe_len: got %0d want 3", nstrobe); end
        checks++;
        if (npulse != 1) begin errors++; $display("FAIL write_rsp_count: got %0d want 1", npulse); end
        checks++;
        if (nlow != 4) begin errors++; $display("FAIL write_ready_low: got %0d want 4", nlow); end
    endtask

    task automatic test_read();
        logic [15:0] seq [3];
        int k = 0, npulse = 0;
        logic acc;
        seq[0] = 16'h0001; seq[1] = 16'h0002; seq[2] = 16'h3C3C;
        rw[0] = 1'b0; wd[0] = 16'($urandom); recc[0] = 1'($urandom); rv[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            acc = rv[0] && o_ready[0];
            cycle();
            if (acc) begin rv[0] = 1'b0; k = 1; end
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL read_trace cyc%0d: got %h want %h", cyc, obs_vec(0), exp_vec(0));
            end
            checks++;
            if (o_oe[0] !== 1'b0) begin errors++; $display("FAIL read_oe cyc%0d: got %b want 0", cyc, o_oe[0]); end
            if (o_rsp[0]) begin
                npulse++;
                checks++;
                if (o_rdata[0] !== 16'h3C3C || o_ww[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL read_data: got %h/%b want 3c3c/0", o_rdata[0], o_ww[0]);
                end
            end
            if (k >= 1 && k <= 3) begin din[0] = seq[k-1]; k++; end
        end
        checks++;
        if (npulse != 1) begin errors++; $display("FAIL read_rsp_count: got %0d want 1", npulse); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] kinds;
        int idx = 0, nacc = 0, npulse = 0, nturn = 0;
        int acc_t [3];
        logic acc;
        kinds = 3'b101;
        rw[0] = kinds[0]; wd[0] = 16'($urandom); recc[0] = 1'($urandom); rv[0] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            acc = rv[0] && o_ready[0];
            cycle();
            checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL b2b_trace cyc%0d: got %h want %h", cyc, obs_vec(0), exp_vec(0));
            end
            if (acc) begin
                if (nacc < 3) acc_t[nacc] = cyc;
                nacc++;
                idx++;
                if (idx < 3) begin
                    rw[0] = kinds[idx]; wd[0] = 16'($urandom); recc[0] = 1'($urandom);
                end else begin
                    rv[0] = 1'b0;
                end
            end
            if (o_rsp[0]) npulse++;
            if (o_rsp[0] && o_cs[0]) nturn++;
        end
        checks++;
        if (nacc != 3) begin
            errors++; $display("FAIL b2b_accepts: got %0d want 3", nacc);
        end else begin
            for (int j = 1; j < 3; j++) begin
                checks++;
                if (acc_t[j] - acc_t[j-1] != 5) begin
                    errors++; $display("FAIL b2b_spacing%0d: got %0d want 5", j, acc_t[j] - acc_t[j-1]);
                end
            end
        end
        checks++;
        if (npulse != 3) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 3", npulse); end
        checks++;
        if (nturn != 3) begin errors++; $display("FAIL b2b_turn_count: got %0d want 3", nturn); end
    endtask

    task automatic test_reset_mid();
        rw[0] = 1'b1; wd[0] = 16'($urandom); recc[0] = 1'b0; rv[0] = 1'b1;
        cycle();
        rv[0] = 1'b0;
        cycle();
        checks++;
        if (o_cs[0] !== 1'b0 || o_oe[0] !== 1'b1 || o_ecc[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: cs=%b oe=%b ecc=%b want 0 1 0", o_cs[0], o_oe[0], o_ecc[0]);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL rstmid_trace: got %h want %h", obs_vec(0), exp_vec(0));
        end
        checks++;
        if (o_cs[0] !== 1'b1 || o_we[0] !== 1'b1 || o_oe[0] !== 1'b0 || o_ecc[0] !== 1'b1 ||
            o_rsp[0] !== 1'b0 || o_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_outputs: cs=%b we=%b oe=%b ecc=%b rsp=%b ready=%b want 1 1 0 1 0 1",
                     o_cs[0], o_we[0], o_oe[0], o_ecc[0], o_rsp[0], o_ready[0]);
        end
        for (int n = 0; n < 6; n++) begin
            cycle();
            checks++;
            if (o_rsp[0] !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp cyc%0d: got 1 want 0", cyc); end
        end
    endtask

    task automatic test_wait0();
        int nacc = 0, ncs = 0, run = 0, maxrun = 0;
        logic acc;
        rw[1] = 1'b0; wd[1] = 16'($urandom); recc[1] = 1'b1; rv[1] = 1'b1;
        for (int n = 0; n < 12; n++) begin
            acc = rv[1] && o_ready[1];
            cycle();
            checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL w0_trace cyc%0d: got %h want %h", cyc, obs_vec(1), exp_vec(1));
            end
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    rw[1] = 1'b1; wd[1] = 16'($urandom); recc[1] = 1'b0;
                end else begin
                    rv[1] = 1'b0;
                end
            end
            if (nacc >= 2) begin
                checks++;
                if (o_ecc[1] !== 1'b0) begin errors++; $display("FAIL w0_ecc cyc%0d: got %b want 0", cyc, o_ecc[1]); end
            end
            if (!o_cs[1]) begin ncs++; run++; if (run > maxrun) maxrun = run; end else run = 0;
        end
        checks++;
        if (ncs != 2 || maxrun != 1) begin
            errors++; $display("FAIL w0_access_len: got total %0d run %0d want 2 and 1", ncs, maxrun);
        end
    endtask

    task automatic test_random();
        logic [1:0] acc;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && $urandom_range(2) == 0) begin
                    rw[i] = 1'($urandom); wd[i] = 16'($urandom); recc[i] = 1'($urandom); rv[i] = 1'b1;
                end
                acc[i] = rv[i] && o_ready[i];
            end
            cycle();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) rv[i] = 1'b0;
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random_trace inst%0d cyc%0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
                end
            end
        end
        rv = 2'b00;
    endtask

    initial begin
        wd[0] = '0; wd[1] = '0; din[0] = '0; din[1] = '0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_wr[i] = 1'b0; m_ecc[i] = 1'b1; m_dout[i] = '0; m_rdata[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_wait0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
